// File: rtl/snake_engine.sv
// Snake game-state core: segment storage, stepping, grow/collision and the per-pixel cell lookup.
// Optional build macro SNAKE_WRAP_EN removes the walls and wraps the head around the grid edges.
module snake_engine #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_en,
  input  logic [1:0] dir,
  input  logic [5:0] apple_x,
  input  logic [4:0] apple_y,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [1:0] snake,
  output logic       eat,
  output logic [6:0] length,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_BODY = 2'b10;
  localparam logic [1:0] C_WALL = 2'b11;

  localparam logic [6:0] LEN_INIT = 7'(INIT_LEN);
  localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);

  logic [1:0] r_state;
  logic [5:0] r_seg_x [MAX_LEN];
  logic [4:0] r_seg_y [MAX_LEN];
  logic [6:0] r_len;
  logic [1:0] r_dir;
  logic       r_eat;
  logic [1:0] r_snake;

  logic [1:0] w_dir;
  logic [5:0] w_nx;
  logic [4:0] w_ny;
  logic       w_grow;
  logic       w_wall;
  logic       w_self;
  logic [6:0] w_lim;
  logic       w_load;
  logic       w_move;
  logic       w_crash;

  logic [5:0] w_cx;
  logic [5:0] w_cy;
  logic       w_border;
  logic       w_head;
  logic       w_body;
  logic [1:0] w_code;

  // Next head position, grow and collision decision for a step.
  always_comb begin
    // The reverse of any direction differs only in bit 0.
    if (dir == {r_dir[1], ~r_dir[0]}) begin
      w_dir = r_dir;
    end else begin
      w_dir = dir;
    end
    w_nx = r_seg_x[0];
    w_ny = r_seg_y[0];
    // Edge wrap is harmless without SNAKE_WRAP_EN: a live head never sits on a border cell there.
    case (w_dir)
      D_UP:    w_ny = (r_seg_y[0] == 5'd0)  ? 5'd29 : r_seg_y[0] - 5'd1;
      D_DOWN:  w_ny = (r_seg_y[0] == 5'd29) ? 5'd0  : r_seg_y[0] + 5'd1;
      D_LEFT:  w_nx = (r_seg_x[0] == 6'd0)  ? 6'd39 : r_seg_x[0] - 6'd1;
      D_RIGHT: w_nx = (r_seg_x[0] == 6'd39) ? 6'd0  : r_seg_x[0] + 6'd1;
      default: w_nx = r_seg_x[0];
    endcase
    w_grow = (w_nx == apple_x) && (w_ny == apple_y);
`ifdef SNAKE_WRAP_EN
    w_wall = 1'b0;
`else
    w_wall = (w_nx == 6'd0) || (w_nx == 6'd39) || (w_ny == 5'd0) || (w_ny == 5'd29);
`endif
    // The tail vacates its cell on a plain move, so it only counts when growing.
    w_lim  = w_grow ? r_len : r_len - 7'd1;
    w_self = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      w_self = w_self | ((7'(i) < w_lim) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny));
    end
    w_load  = start && (r_state != S_RUN);
    w_crash = (r_state == S_RUN) && step_en && (w_wall || w_self);
    w_move  = (r_state == S_RUN) && step_en && !(w_wall || w_self);
  end

  // Classify the grid cell under the scan position.
  always_comb begin
    w_cx = x_pos[9:4];
    w_cy = y_pos[9:4];
`ifdef SNAKE_WRAP_EN
    w_border = 1'b0;
`else
    w_border = (w_cx == 6'd0) || (w_cx == 6'd39) || (w_cy == 6'd0) || (w_cy == 6'd29);
`endif
    w_head = (r_seg_x[0] == w_cx) && ({1'b0, r_seg_y[0]} == w_cy);
    w_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      w_body = w_body | ((7'(i) < r_len) && (r_seg_x[i] == w_cx) && ({1'b0, r_seg_y[i]} == w_cy));
    end
    if ((x_pos >= 10'd640) || (y_pos >= 10'd480)) begin
      w_code = C_NONE;
    end else if (w_border) begin
      w_code = C_WALL;
    end else if (w_head) begin
      w_code = C_HEAD;
    end else if (w_body) begin
      w_code = C_BODY;
    end else begin
      w_code = C_NONE;
    end
  end

  // Game FSM, segment shift register, length and eat pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_len   <= LEN_INIT;
      r_dir   <= D_RIGHT;
      r_eat   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= 6'd20 - 6'(i);
        r_seg_y[i] <= 5'd15;
      end
    end else begin
      r_eat <= 1'b0;
      if (w_load) begin
        r_state <= S_RUN;
        r_len   <= LEN_INIT;
        r_dir   <= D_RIGHT;
        for (int i = 0; i < MAX_LEN; i++) begin
          r_seg_x[i] <= 6'd20 - 6'(i);
          r_seg_y[i] <= 5'd15;
        end
      end else if (w_crash) begin
        r_state <= S_OVER;
      end else if (w_move) begin
        r_dir      <= w_dir;
        r_seg_x[0] <= w_nx;
        r_seg_y[0] <= w_ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_eat <= w_grow;
        if (w_grow && (r_len < LEN_MAX)) begin
          r_len <= r_len + 7'd1;
        end else begin
          r_len <= r_len;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

  // Registered cell code for the VGA stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snake <= C_NONE;
    end else begin
      r_snake <= w_code;
    end
  end

  assign snake     = r_snake;
  assign eat       = r_eat;
  assign length    = r_len;
  assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: queue-based game model compared every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_snake_engine;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       step_en = 1'b0;
  logic [1:0] dir = 2'b11;
  logic [5:0] apple_x = 6'd5;
  logic [4:0] apple_y = 5'd5;
  logic [9:0] x_pos = 10'd0;
  logic [9:0] y_pos = 10'd0;
  logic [1:0] snake;
  logic       eat;
  logic [6:0] length;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 run, 2 over; body[0] is the head, cells keyed x*64+y
  int m_state = 0;
  int body[$];
  int m_dir = 3;
  int m_snake = 0;
  int m_eat = 0;

  always #5 clk = ~clk;

  snake_engine #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .step_en(step_en), .dir(dir),
    .apple_x(apple_x), .apple_y(apple_y), .x_pos(x_pos), .y_pos(y_pos),
    .snake(snake), .eat(eat), .length(length), .game_over(game_over)
  );

  function automatic int key(int x, int y);
    return x * 64 + y;
  endfunction

  function automatic int opposite(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int lookup(int xp, int yp);
    int cx, cy;
    if (xp >= 640 || yp >= 480) return 0;
    cx = xp / 16;
    cy = yp / 16;
    if (!WRAP && (cx == 0 || cx == 39 || cy == 0 || cy == 29)) return 3;
    if (body[0] == key(cx, cy)) return 1;
    for (int k = 1; k < body.size(); k++) if (body[k] == key(cx, cy)) return 2;
    return 0;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_layout();
    body.delete();
    for (int i = 0; i < INIT_LEN; i++) body.push_back(key(20 - i, 15));
    m_dir = 3;
  endtask

  task automatic do_step();
    int hx, hy, nd, nx, ny, lim;
    bit grow, hit;
    hx = body[0] / 64;
    hy = body[0] % 64;
    nd = (int'(dir) == opposite(m_dir)) ? m_dir : int'(dir);
    nx = hx;
    ny = hy;
    case (nd)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    if (WRAP) begin
      nx = (nx + 40) % 40;
      ny = (ny + 30) % 30;
    end
    grow = (nx == int'(apple_x)) && (ny == int'(apple_y));
    hit  = !WRAP && (nx == 0 || nx == 39 || ny == 0 || ny == 29);
    lim  = grow ? body.size() : body.size() - 1;
    for (int k = 1; k < lim; k++) if (body[k] == key(nx, ny)) hit = 1'b1;
    if (hit) begin
      m_state = 2;
    end else begin
      m_dir = nd;
      body.push_front(key(nx, ny));
      if (!grow || body.size() > MAX_LEN) void'(body.pop_back());
      m_eat = grow ? 1 : 0;
    end
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then compare all outputs.
  task automatic tick();
    @(posedge clk);
    if (rst == 1'b0) begin
      model_layout();
      m_state = 0;
      m_snake = 0;
      m_eat   = 0;
    end else begin
      m_snake = lookup(int'(x_pos), int'(y_pos));
      m_eat   = 0;
      if (m_state != 1) begin
        if (start) begin
          model_layout();
          m_state = 1;
        end
      end else if (step_en) begin
        do_step();
      end
    end
    @(negedge clk);
    check("snake", int'(snake), m_snake);
    check("eat", int'(eat), m_eat);
    check("length", int'(length), body.size());
    check("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic step_dir(int d);
    dir = 2'(d);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
  endtask

  task automatic scan(int xp, int yp);
    x_pos = 10'(xp);
    y_pos = 10'(yp);
    tick();
  endtask

  task automatic set_apple(int x, int y);
    apple_x = 6'(x);
    apple_y = 5'(y);
  endtask

  initial begin
    int hx, hy, d, idx, kk;

    // reset state
    x_pos = 10'd700;
    rst = 1'b0;
    tick();
    check("reset_snake", int'(snake), 0);
    check("reset_eat", int'(eat), 0);
    check("reset_length", int'(length), 3);
    check("reset_game_over", int'(game_over), 0);
    rst = 1'b1;

    // three steps right
    pulse_start();
    for (int i = 0; i < 3; i++) step_dir(3);
    check("run3_length", int'(length), 3);
    check("run3_eat", int'(eat), 0);
    scan(368, 240);
    check("run3_head_23_15", int'(snake), 1);
    scan(336, 240);
    check("run3_body_21_15", int'(snake), 2);

    // eat an apple
    do_reset();
    pulse_start();
    set_apple(21, 15);
    step_dir(3);
    check("eat_pulse", int'(eat), 1);
    check("eat_length", int'(length), 4);
    set_apple(5, 5);
    scan(288, 240);
    check("eat_once", int'(eat), 0);
    check("eat_tail_18_15", int'(snake), 2);
    scan(272, 240);
    check("eat_beyond_tail", int'(snake), 0);

    // reversal is ignored
    do_reset();
    pulse_start();
    step_dir(2);
    scan(336, 240);
    check("reverse_head_21_15", int'(snake), 1);
    check("reverse_game_over", int'(game_over), 0);

    // fifteen steps up
    do_reset();
    pulse_start();
    for (int i = 0; i < 15; i++) step_dir(0);
`ifdef SNAKE_WRAP_EN
    check("up15_wrap_alive", int'(game_over), 0);
    scan(320, 0);
    check("up15_wrap_head_20_0", int'(snake), 1);
`else
    check("up15_game_over", int'(game_over), 1);
    scan(320, 16);
    check("up15_frozen_head", int'(snake), 1);
    step_dir(0);
    scan(320, 16);
    check("over_step_ignored", int'(snake), 1);
    check("over_length", int'(length), 3);
    pulse_start();
    check("restart_game_over", int'(game_over), 0);
    scan(320, 240);
    check("restart_head_20_15", int'(snake), 1);
    check("restart_length", int'(length), 3);
`endif

    // self collision at length 5
    do_reset();
    pulse_start();
    set_apple(21, 15);
    step_dir(3);
    set_apple(22, 15);
    step_dir(3);
    set_apple(5, 5);
    check("grow5_length", int'(length), 5);
    step_dir(1);
    step_dir(2);
    step_dir(0);
    check("self_hit_game_over", int'(game_over), 1);

    // chasing the vacating tail at length 4
    do_reset();
    pulse_start();
    set_apple(21, 15);
    step_dir(3);
    set_apple(5, 5);
    step_dir(1);
    step_dir(2);
    step_dir(0);
    check("tail_chase_alive", int'(game_over), 0);
    scan(320, 240);
    check("tail_chase_head", int'(snake), 1);

    // run into the right edge
    do_reset();
    pulse_start();
    for (int i = 0; i < 19; i++) step_dir(3);
`ifdef SNAKE_WRAP_EN
    check("edge_x39_alive", int'(game_over), 0);
    step_dir(3);
    scan(0, 240);
    check("wrap_head_0_15", int'(snake), 1);
    check("wrap_game_over", int'(game_over), 0);
    scan(0, 0);
    check("wrap_corner_none", int'(snake), 0);
`else
    check("edge_wall_game_over", int'(game_over), 1);
    scan(608, 240);
    check("edge_frozen_head", int'(snake), 1);
    scan(0, 0);
    check("corner_wall", int'(snake), 3);
    scan(640, 100);
    check("offscreen_none", int'(snake), 0);
`endif

    // randomized play
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) != 0);
      d = int'($urandom_range(0, 3));
      dir = 2'(d);
      step_en = ($urandom_range(0, 2) == 0);
      start = (m_state != 1) && ($urandom_range(0, 7) == 0);
      hx = body[0] / 64;
      hy = body[0] % 64;
      if ($urandom_range(0, 1) == 0) begin
        case (d)
          0: hy = hy - 1;
          1: hy = hy + 1;
          2: hx = hx - 1;
          default: hx = hx + 1;
        endcase
        set_apple((hx + 40) % 40, (hy + 30) % 30);
      end else begin
        set_apple(int'($urandom_range(0, 39)), int'($urandom_range(0, 29)));
      end
      if ($urandom_range(0, 1) == 0) begin
        idx = int'($urandom_range(0, body.size() - 1));
        kk = body[idx];
        x_pos = 10'((kk / 64) * 16 + int'($urandom_range(0, 15)));
        y_pos = 10'((kk % 64) * 16 + int'($urandom_range(0, 15)));
      end else begin
        x_pos = 10'($urandom_range(0, 700));
        y_pos = 10'($urandom_range(0, 520));
      end
      tick();
    end
    rst = 1'b1;
    start = 1'b0;
    step_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Game-state core for the snake display path: holds the snake's segment coordinates on the 40×30 grid of 16×16-pixel cells and advances the snake one cell per step pulse. It grows the snake when the head lands on the apple and detects wall and self collisions. Each cycle it classifies the cell under the current VGA scan position and drives the 2-bit `snake` cell code consumed directly by the VGA control stage.

## Interface
Parameters:
- MAX_LEN, 16, segment register capacity (≥ INIT_LEN, ≤ 64)
- INIT_LEN, 3, length after reset/restart (≥ 2)

Ports:
- clk  in  1  system clock (VGA pixel clock domain)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: leave IDLE, or restart from OVER
- step_en  in  1  one-cycle move tick
- dir  in  2  requested direction: 00 up, 01 down, 10 left, 11 right
- apple_x  in  6  apple cell column (0–39)
- apple_y  in  5  apple cell row (0–29)
- x_pos  in  10  current scan pixel column from VGA control
- y_pos  in  10  current scan pixel row from VGA control
- snake  out  2  cell code at the scan position: 00 NONE, 01 HEAD, 10 BODY, 11 WALL
- eat  out  1  one-cycle pulse on an apple eaten
- length  out  7  active segment count
- game_over  out  1  high while in OVER

## Operation
- Segments: seg[0] is the head, seg[length-1] is the tail. Each segment is a 6-bit x and a 5-bit y.
- Initial layout (reset/restart):
  - head at (20,15); seg[i] = (20−i, 15)
  - cur_dir = right; length = INIT_LEN
- FSM:
  - IDLE →(start) RUN
  - RUN →(collision) OVER
  - OVER →(start) RUN, reloading the initial layout in the same edge
  - start in RUN is ignored.
- Direction: on a step, `dir` is adopted unless it is the exact reverse of cur_dir, in which case cur_dir is kept.
- Step (RUN, step_en=1):
  - nh = seg[0] moved one cell in cur_dir
  - grow = (nh == apple)
  - Collision if nh is a border cell (x=0, x=39, y=0, y=29).
  - Collision if nh matches seg[1..length-1]. The tail is excluded when grow=0 and included when grow=1.
  - On collision: segments and length are frozen, game_over=1, go to OVER.
  - Otherwise: seg[i] ← seg[i-1] for i≥1, seg[0] ← nh.
  - If grow: eat pulses; length += 1, saturating at MAX_LEN. At saturation eat still pulses and the tail still advances.
- Lookup: cell = (x_pos[9:4], y_pos[9:4]).
  - x_pos ≥ 640 or y_pos ≥ 480 → NONE.
  - Else priority is WALL (border) > HEAD (seg[0]) > BODY (any seg[1..length-1]) > NONE.
  - The apple is not reported; VGA control overlays it itself.
- step_en in IDLE/OVER is ignored. start and step_en in the same cycle: start wins, no move.

## Timing
- Reset (rst=0, async):
  - FSM = IDLE, initial layout loaded
  - snake = 00, eat = 0, length = INIT_LEN, game_over = 0
- Step latency is 1 cycle. seg, length, eat and game_over update on the edge that samples step_en=1.
- eat is high for exactly the cycle after that edge.
- Lookup latency is 1 cycle. snake is registered from the x_pos/y_pos sampled on the previous edge.
- During a step edge, the lookup uses the pre-step segments. The new segments are visible from the next lookup.
- Comparators: the lookup uses MAX_LEN parallel compares qualified by i < length. The step logic uses its own MAX_LEN compares. There is no multi-cycle search.
- Reset asserted mid-step aborts the step with no partial update.

## Configuration
- SNAKE_WRAP_EN defined:
  - No walls. The head wraps (x 39→0, 0→39; y 29→0, 0→29).
  - Border cells are ordinary cells; the lookup never outputs WALL.
  - Only self collision ends the game.
- Undefined: border cells are WALL, and entering one ends the game as above.

## Test plan
- Reset, then start, then 3 step_en pulses with dir=11:
  - head = (23,15), length = 3, eat never high
  - scan pos (368,240) → HEAD one cycle later; (336,240) → BODY
- Apple at (21,15), one step right:
  - eat high 1 cycle, length = 4, tail still at (18,15)
- Start, then dir=10 (reverse) with one step:
  - reversal ignored, head = (21,15), game_over = 0
- Steer up from row 15 for 15 steps:
  - the 15th step reaches y=0 → game_over = 1 and segments frozen
  - further step_en has no effect; start → head (20,15), length = 3, RUN
- Grow to length 5, then steps down, left, up:
  - the head enters a body cell → game_over = 1
  - moving into the vacating tail cell with length 4 and no apple → no collision
- SNAKE_WRAP_EN:
  - head at (39,15) stepping right → head (0,15), no game_over
  - scan pos (0,0) → NONE
